// File: rtl/tt_instr_sequencer.sv
// Host-side instruction sequencer for the 6-bit tinytapeout CPU: holds a small
// writable program, issues one word per cycle, follows cjump redirects and captures cpu_out changes.
module tt_instr_sequencer #(
  parameter int          DEPTH   = 32,
  parameter int          PC_W    = 5,
  parameter logic [5:0]  HALT_OP = 6'h3F,
  parameter logic [5:0]  NOP_OP  = 6'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [5:0]      prog_data,
  input  logic            start,
  input  logic            stop,
  input  logic            cjump,
  input  logic [4:0]      cpu_out,
  output logic [5:0]      instr,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
  output logic            out_valid,
  output logic [4:0]      out_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [5:0]      instr_q, instr_d;
  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_data_q, out_data_d;
  logic [5:0]      mem_q [DEPTH];
  logic [5:0]      word_s;
  logic            mem_we_s;

  assign word_s   = mem_q[pc_q];
  assign mem_we_s = prog_we && (state_q != S_RUN);

  // State, fetch pointer, issued instruction and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= NOP_OP;
      out_valid_q <= 1'b0;
      out_data_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Program memory; cleared to NOP on reset, writable only while not running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_OP;
      end
    end else if (mem_we_s) begin
      mem_q[prog_addr] <= prog_data;
    end else begin
      mem_q[prog_addr] <= mem_q[prog_addr];
    end
  end

  // Next-state, next-pc and issue selection; stop outranks every RUN action
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = NOP_OP;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start && !stop) begin
          state_d = S_RUN;
          pc_d    = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (stop || (word_s == HALT_OP)) begin
          state_d = S_HALT;
        end else begin
          instr_d = word_s;
          if (cjump) begin
            pc_d = cpu_out[PC_W-1:0];
          end else begin
            pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Output capture: one pulse per change of cpu_out, in every state
  always_comb begin
    if (cpu_out != out_data_q) begin
      out_valid_d = 1'b1;
      out_data_d  = cpu_out;
    end else begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
  end

  // Status decode from the current state
  always_comb begin
    running = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_RUN:   running = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: begin
        running = 1'b0;
        halted  = 1'b0;
      end
    endcase
  end

  assign instr     = instr_q;
  assign pc        = pc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_tt_instr_sequencer.sv
// Self-checking bench for tt_instr_sequencer: table-driven linear run, directed
// corner sequences and randomized traffic checked against a behavioural model.
module tb_tt_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [5:0] prog_data;
  logic       start, stop, cjump;
  logic [4:0] cpu_out;
  logic [5:0] instr;
  logic [4:0] pc;
  logic       running, halted, out_valid;
  logic [4:0] out_data;

  int tests = 0;
  int fails = 0;

  // Behavioural model: 0=idle, 1=run, 2=halt
  int         m_state;
  int         m_pc;
  logic [5:0] m_instr;
  logic [5:0] m_mem [32];
  logic       m_ov;
  logic [4:0] m_od;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [5:0] data;
    logic       st;
    logic       sp;
    logic [5:0] e_instr;
    logic [4:0] e_pc;
    logic       e_run;
    logic       e_halt;
  } vec_t;

  vec_t tbl [10];

  tt_instr_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .stop(stop), .cjump(cjump),
    .cpu_out(cpu_out), .instr(instr), .pc(pc), .running(running),
    .halted(halted), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_instr = 6'h00;
    m_ov    = 1'b0;
    m_od    = 5'd0;
    for (int i = 0; i < 32; i++) m_mem[i] = 6'h00;
  endtask

  // Apply one clock edge of the specification's rules to the model
  task automatic model_step();
    logic [5:0] w;
    m_ov = (cpu_out != m_od);
    if (m_ov) m_od = cpu_out;
    if (m_state == 1) begin
      w = m_mem[m_pc];
      if (stop || w == 6'h3F) begin
        m_state = 2;
        m_instr = 6'h00;
      end else begin
        m_instr = w;
        m_pc = cjump ? int'(cpu_out) % 32 : (m_pc + 1) % 32;
      end
    end else begin
      if (prog_we) m_mem[prog_addr] = prog_data;
      m_instr = 6'h00;
      if (start && !stop) begin
        m_state = 1;
        m_pc    = 0;
      end
    end
  endtask

  task automatic compare_model();
    check("instr", 32'(instr), 32'(m_instr));
    check("pc", 32'(pc), 32'(m_pc));
    check("running", 32'(running), 32'(m_state == 1));
    check("halted", 32'(halted), 32'(m_state == 2));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
  endtask

  // Drive inputs just after an edge, take the next edge, then compare
  task automatic cycle(input logic we, input logic [4:0] a, input logic [5:0] d,
                       input logic st, input logic sp, input logic cj, input logic [4:0] co);
    prog_we = we; prog_addr = a; prog_data = d;
    start = st; stop = sp; cjump = cj; cpu_out = co;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_cycle(input logic [4:0] co);
    cycle(1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 1'b0, co);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [5:0] d);
    cycle(1'b1, a, d, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int pulses;
    logic [4:0] cap_seq [6];

    tbl[0] = '{1'b1, 5'd0, 6'h05, 1'b0, 1'b0, 6'h00, 5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd1, 6'h0A, 1'b0, 1'b0, 6'h00, 5'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd2, 6'h11, 1'b0, 1'b0, 6'h00, 5'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd3, 6'h3F, 1'b0, 1'b0, 6'h00, 5'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 6'h00, 5'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'h05, 5'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'h0A, 5'd2, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'h11, 5'd3, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'h00, 5'd3, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 6'h00, 5'd3, 1'b0, 1'b1};

    rst = 1'b1; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 6'h00;
    start = 1'b0; stop = 1'b0; cjump = 1'b0; cpu_out = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_pc", 32'(pc), 32'd0);
    rst = 1'b0;

    // Linear run from the vector table
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].st, tbl[i].sp, 1'b0, 5'd0);
      check($sformatf("tbl%0d_instr", i), 32'(instr), 32'(tbl[i].e_instr));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].e_pc));
      check($sformatf("tbl%0d_run", i), 32'(running), 32'(tbl[i].e_run));
      check($sformatf("tbl%0d_halt", i), 32'(halted), 32'(tbl[i].e_halt));
    end

    // Reset asserted mid-RUN, away from the clock edge
    write_word(5'd3, 6'h12);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd4);
    idle_cycle(5'd4);
    idle_cycle(5'd4);
    #2 rst = 1'b1;
    #1;
    check("midrst_instr", 32'(instr), 32'h00);
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_run", 32'(running), 32'd0);
    check("midrst_halt", 32'(halted), 32'd0);
    check("midrst_ov", 32'(out_valid), 32'd0);
    check("midrst_od", 32'(out_data), 32'd0);
    model_reset();
    cpu_out = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle(5'd0);
    check("no_autostart", 32'(running), 32'd0);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle(5'd0);
      check($sformatf("cleared_mem%0d", i), 32'(instr), 32'h00);
    end
    cycle(1'b0, 5'd0, 6'h00, 1'b0, 1'b1, 1'b0, 5'd0);
    check("stop_halts", 32'(halted), 32'd1);

    // Jump: redirect at pc=1 to 9; word 03 must never issue
    write_word(5'd0, 6'h01);
    write_word(5'd1, 6'h02);
    write_word(5'd2, 6'h03);
    write_word(5'd9, 6'h3F);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    idle_cycle(5'd0);
    check("jmp_i0", 32'(instr), 32'h01);
    cycle(1'b0, 5'd0, 6'h00, 1'b0, 1'b0, 1'b1, 5'd9);
    check("jmp_i1", 32'(instr), 32'h02);
    check("jmp_pc", 32'(pc), 32'd9);
    idle_cycle(5'd9);
    check("jmp_halt", 32'(halted), 32'd1);
    check("jmp_halt_pc", 32'(pc), 32'd9);
    check("jmp_halt_instr", 32'(instr), 32'h00);

    // Wrap: all 32 words non-halt, pc 31 -> 0
    for (int i = 0; i < 32; i++) write_word(5'(i), 6'(i + 1));
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= 32; k++) begin
      idle_cycle(5'd0);
      if (k == 31) check("wrap_pc31", 32'(pc), 32'd31);
    end
    check("wrap_pc0", 32'(pc), 32'd0);
    check("wrap_instr", 32'(instr), 32'h20);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b1, 1'b0, 5'd0);
    check("stopstart_halt", 32'(halted), 32'd1);
    check("stopstart_instr", 32'(instr), 32'h00);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b1, 1'b0, 5'd0);
    check("both_stay_halt", 32'(halted), 32'd1);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_run", 32'(running), 32'd1);

    // Write protection in RUN, write accepted in HALT
    cycle(1'b1, 5'd2, 6'h2A, 1'b0, 1'b0, 1'b0, 5'd0);
    idle_cycle(5'd0);
    idle_cycle(5'd0);
    check("wp_run_word2", 32'(instr), 32'h03);
    cycle(1'b0, 5'd0, 6'h00, 1'b0, 1'b1, 1'b0, 5'd0);
    write_word(5'd2, 6'h2A);
    cycle(1'b0, 5'd0, 6'h00, 1'b1, 1'b0, 1'b0, 5'd0);
    repeat (3) idle_cycle(5'd0);
    check("wp_halt_word2", 32'(instr), 32'h2A);
    cycle(1'b0, 5'd0, 6'h00, 1'b0, 1'b1, 1'b0, 5'd0);

    // Capture: 3,3,7,7,7,0 -> three pulses
    idle_cycle(5'd0);
    cap_seq = '{5'd3, 5'd3, 5'd7, 5'd7, 5'd7, 5'd0};
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      idle_cycle(cap_seq[i]);
      if (out_valid) pulses++;
      check($sformatf("cap%0d_od", i), 32'(out_data), 32'(cap_seq[i]));
    end
    check("cap_pulses", 32'(pulses), 32'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] d;
      d = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom);
      cycle(1'($urandom_range(0, 2) == 0), 5'($urandom), d,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0) ? out_data : 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
